// File: rtl/qam_frame_buffer_ctrl_if.sv
// Symbol-in / symbol-out bus between the demapper, the frame buffer and the host.
// The master side is the demapper plus host; the slave side is the buffer controller.
interface qam_frame_buffer_ctrl_if #(
   parameter int SYM_BITS = 4
);
   logic                sym_valid;
   logic [SYM_BITS-1:0] sym_data;
   logic                read_enable;
   logic [SYM_BITS-1:0] rd_data;
   logic                rd_valid;
   logic                available;
   logic                complete;

   modport master (
      output sym_valid, sym_data, read_enable,
      input  rd_data, rd_valid, available, complete
   );

   modport slave (
      input  sym_valid, sym_data, read_enable,
      output rd_data, rd_valid, available, complete
   );
endinterface

// File: rtl/qam_frame_buffer_ctrl.sv
// Frame buffer for the hard-decision QAM demapper: gathers FRAME_LEN symbols in a FIFO,
// flags the host, drains on request and counts symbols dropped while a frame is held.
module qam_frame_buffer_ctrl #(
   parameter int SYM_BITS  = 4,
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 16,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                  dclk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  continuous,
   qam_frame_buffer_ctrl_if.slave bus,
   output logic [AW:0]           level,
   output logic [15:0]           overflow_cnt,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RECEIVE = 2'b01,
      READY   = 2'b10,
      READOUT = 2'b11
   } state_t;

   localparam logic [AW:0] LAST_WR = (AW+1)'(FRAME_LEN - 1);
   localparam logic [AW:0] LAST_RD = (AW+1)'(1);

   state_t              st;
   logic [SYM_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [SYM_BITS-1:0] rd_data_q;
   logic                rd_valid_q;
   logic                available_q;
   logic                complete_q;
   logic                wr_en;
   logic                pop;
   logic                drop;

   // A disabled block neither stores, pops nor counts anything.
   assign wr_en = enable && bus.sym_valid && (st == RECEIVE);
   assign pop   = enable && bus.read_enable && (st == READOUT);
   assign drop  = enable && bus.sym_valid && ((st == READY) || (st == READOUT));

   // NOTE: the storage array carries no reset; level and the pointers define what is valid,
   // so clearing the entries would only cost reset fan-out.
   always_ff @(posedge dclk) begin
      if (wr_en) mem[wr_ptr] <= bus.sym_data;
   end

   // NOTE: every state register uses non-blocking assignment so all updates see the
   // pre-edge values, matching the one-cycle read latency the host expects.
   always_ff @(posedge dclk or negedge reset) begin
      if (!reset) begin
         st           <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         overflow_cnt <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         available_q  <= 1'b0;
         complete_q   <= 1'b0;
      end else begin
         complete_q <= 1'b0;
         rd_valid_q <= pop;
         if (pop) rd_data_q <= mem[rd_ptr];
         if (drop && (overflow_cnt != 16'hFFFF)) overflow_cnt <= overflow_cnt + 16'd1;

         if (!enable) begin
            st          <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            available_q <= 1'b0;
         end else begin
            unique case (st)
               IDLE: st <= RECEIVE;
               RECEIVE: begin
                  if (wr_en) begin
                     wr_ptr <= wr_ptr + 1'b1;
                     level  <= level + 1'b1;
                     if (level == LAST_WR) begin
                        st          <= READY;
                        available_q <= 1'b1;
                     end
                  end
               end
               READY: begin
                  if (bus.read_enable) st <= READOUT;
               end
               READOUT: begin
                  if (pop) begin
                     rd_ptr <= rd_ptr + 1'b1;
                     level  <= level - 1'b1;
                     if (level == LAST_RD) begin
                        complete_q  <= 1'b1;
                        available_q <= 1'b0;
                        st          <= continuous ? RECEIVE : IDLE;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.available = available_q;
   assign bus.complete  = complete_q;
   assign state         = st;

endmodule

// File: doc/qam_frame_buffer_ctrl.md
# qam_frame_buffer_ctrl

Parametrised frame-buffering controller for the hard-decision QAM demapper. Accepts demapped symbols from the demapper core, gathers them into a frame held in an internal FIFO, and flags the host when a frame is ready. It then drains the frame to the host on request and reports dropped symbols. It supersedes the fixed 2-bit-state controller, adding:
- an internal FIFO with configurable depth and width
- a configurable frame length
- one-shot and continuous modes
- an overflow counter

## Interface
Parameters:
- SYM_BITS, 4, bits per demapped symbol (4 = 16-QAM, 6 = 64-QAM)
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- FRAME_LEN, 16, symbols per frame; 1 ≤ FRAME_LEN ≤ DEPTH
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- dclk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  block enable; low flushes the frame and returns to IDLE
- continuous  in  1  0 = one-shot (IDLE after readout), 1 = continuous (RECEIVE after readout)
- sym_valid  in  1  sym_data valid this cycle
- sym_data  in  SYM_BITS  demapped symbol
- read_enable  in  1  host pop request
- rd_data  out  SYM_BITS  popped symbol (registered)
- rd_valid  out  1  rd_data valid this cycle
- available  out  1  frame held, not yet fully drained
- complete  out  1  one-cycle pulse when the last frame symbol is popped
- level  out  AW+1  symbols currently stored
- overflow_cnt  out  16  saturating count of dropped symbols
- state  out  2  00 IDLE, 01 RECEIVE, 10 READY, 11 READOUT

## Operation
- **Reset (reset = 0):**
  - state IDLE; pointers, level, overflow_cnt, rd_data cleared.
  - rd_valid, available, complete all 0.
  - Asserting reset mid-frame discards everything immediately.
- **IDLE:**
  - sym_valid is ignored and not counted.
  - enable = 1 moves to RECEIVE next cycle.
- **RECEIVE:**
  - Each sym_valid writes sym_data and increments level.
  - The write that brings level to FRAME_LEN moves to READY next cycle.
- **READY:**
  - available = 1.
  - read_enable = 1 moves to READOUT next cycle; the sampling cycle does not pop.
- **READOUT:**
  - available = 1.
  - Each cycle with read_enable = 1 pops one entry; gaps in read_enable pause the drain.
  - The pop that empties the FIFO raises complete for one cycle and drops available.
  - Next state is RECEIVE if continuous = 1, else IDLE.
- **Drops:** sym_valid in READY or READOUT discards the symbol and increments overflow_cnt, saturating at 16'hFFFF.
- **Disable:** enable = 0 in any non-IDLE state:
  - moves to IDLE next cycle and resets pointers and level;
  - pops nothing, raises no complete;
  - retains overflow_cnt, which is cleared only by reset.
- **Simultaneous events:**
  - enable = 0 with sym_valid = 1: the symbol is discarded and not counted.
  - enable = 0 with read_enable = 1: no pop.
  - read_enable in RECEIVE or IDLE is ignored; rd_valid stays 0.
- **Storage:** FIFO pointers wrap modulo DEPTH; level never exceeds FRAME_LEN, so a FIFO-full write cannot occur.

## Timing
- Write: sym_data stored at the rising edge where sym_valid = 1; level updates the same edge.
- State transitions take effect on the rising edge following the condition.
- Read latency is 1 cycle: a pop at edge N gives rd_data and rd_valid = 1 after edge N.
- rd_valid drops the cycle after a cycle with no pop.
- complete is asserted in the same cycle as the rd_valid of the final symbol.
- Throughput is 1 symbol/cycle on both the write and read sides.
- Minimum frame turnaround in continuous mode: first write of the next frame is accepted 1 cycle after complete.

## Test plan
- **Fill and drain (one-shot):** defaults, continuous = 0; write 16 symbols 0..15 back-to-back, then hold read_enable = 1.
  - state goes READY after the 16th write.
  - rd_data sequence 0..15 with rd_valid.
  - complete pulses with symbol 15, then state IDLE, level 0.
- **Overflow:** after a frame reaches READY, drive 5 extra sym_valid.
  - overflow_cnt = 5.
  - Drained data still 0..15.
  - 70000 drops saturate overflow_cnt at 65535.
- **Continuous mode with read gaps:** continuous = 1, read_enable toggled 1/0.
  - 16 pops occur over 32 cycles.
  - complete pulses once, then state RECEIVE.
  - A second frame 16..31 is accepted and read back correctly.
- **Disable mid-frame:** write 7 symbols, drop enable.
  - State IDLE, level 0, no complete.
  - After re-enable, a fresh frame reads from symbol 0 of the new data.
- **Async reset mid-readout:** assert reset between dclk edges during READOUT.
  - All outputs 0 immediately and state IDLE, with no clock edge required.
- **Parameter sweep:** SYM_BITS = 6, DEPTH = 8, FRAME_LEN = 5.
  - READY after 5 writes.
  - 64-QAM values read back intact across pointer wrap over 3 consecutive frames.
